// File: rtl/dac_spi_streamer.sv
// dac_spi_streamer
// Samples an 8-bit audio bus at a fixed rate and streams each sample to a
// serial DAC over a 3-wire SPI link (mode 0, MSB first). Each 16-bit frame is
// {CTRL_BITS, sample, 4'b0000}.
//
// Optional feature macro: DAC_MUTE_EN (adds the mute input; when high on the
// sample tick the transmitted sample is forced to midscale 8'h80).
//
// Ports:
//   c50M        in   50 MHz system clock
//   reset_n     in   asynchronous active-low reset
//   sample_in   in   8-bit unsigned audio sample
//   enable      in   streaming enable; low freezes the sample timer at 0
//   mute        in   (DAC_MUTE_EN only) force midscale on the tick cycle
//   dac_sclk    out  SPI clock, idles low
//   dac_mosi    out  SPI data
//   dac_cs_n    out  SPI chip select, active low
//   busy        out  high whenever a frame is in progress
//   frame_done  out  one-cycle pulse on the first idle cycle after a frame
//   overrun     out  one-cycle pulse when a sample tick is dropped
module dac_spi_streamer #(
   parameter int unsigned SAMPLE_DIV = 6250,
   parameter int unsigned SCLK_DIV   = 5,
   parameter logic [3:0]  CTRL_BITS  = 4'b0011
) (
   input  logic       c50M,
   input  logic       reset_n,
   input  logic [7:0] sample_in,
   input  logic       enable,
`ifdef DAC_MUTE_EN
   input  logic       mute,
`endif
   output logic       dac_sclk,
   output logic       dac_mosi,
   output logic       dac_cs_n,
   output logic       busy,
   output logic       frame_done,
   output logic       overrun
);

   localparam int unsigned TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int unsigned HW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam logic [TW-1:0] TMAX = TW'(SAMPLE_DIV - 1);
   localparam logic [HW-1:0] HMAX = HW'(SCLK_DIV - 1);

   typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

   state_e        state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic          phase_q, phase_d;   // current SCLK level during SHIFT
   logic [3:0]    bit_q, bit_d;
   logic [15:0]   shreg_q, shreg_d;
   logic          done_q, done_d;
   logic          ovr_q, ovr_d;

   logic          tick;
   logic          hdone;
   logic          bit_end;            // end of a high half: one bit period finished
   logic [7:0]    sample_sel;

   assign tick    = enable && (tmr_q == TMAX);
   assign hdone   = (hcnt_q == HMAX);
   assign bit_end = (state_q == StShift) && hdone && phase_q;

`ifdef DAC_MUTE_EN
   assign sample_sel = mute ? 8'h80 : sample_in;
`else
   assign sample_sel = sample_in;
`endif

   // State register
   always_ff @(posedge c50M or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (tick)                  state_d = StSetup;
         StSetup: if (hdone)                 state_d = StShift;
         StShift: if (bit_end && bit_q == 4'd15) state_d = StHold;
         StHold:  if (hdone)                 state_d = StIdle;
         default:                            state_d = StIdle;
      endcase
   end

   // Output decode; combinational so a reset clears the pins in the same cycle
   always_comb begin
      dac_cs_n = 1'b1;
      dac_sclk = 1'b0;
      dac_mosi = 1'b0;
      unique case (state_q)
         StSetup: begin
            dac_cs_n = 1'b0;
            dac_mosi = shreg_q[15];
         end
         StShift: begin
            dac_cs_n = 1'b0;
            dac_sclk = phase_q;
            dac_mosi = shreg_q[15];
         end
         default: ;
      endcase
   end

   assign busy       = (state_q != StIdle);
   assign frame_done = done_q;
   assign overrun    = ovr_q;

   // Datapath next-state
   always_comb begin
      tmr_d   = enable ? ((tmr_q == TMAX) ? '0 : tmr_q + TW'(1)) : '0;
      hcnt_d  = (state_q == StIdle || hdone) ? '0 : hcnt_q + HW'(1);
      phase_d = 1'b0;
      if (state_q == StShift) begin
         phase_d = hdone ? ~phase_q : phase_q;
      end
      bit_d = bit_q;
      if (state_q == StIdle) begin
         bit_d = 4'd0;
      end else if (bit_end) begin
         bit_d = bit_q + 4'd1;
      end
      // MOSI is shreg_q[15]; shifting after each high half makes the next bit
      // appear at the start of the following low half.
      shreg_d = shreg_q;
      if (state_q == StIdle && tick) begin
         shreg_d = {CTRL_BITS, sample_sel, 4'b0000};
      end else if (bit_end) begin
         shreg_d = {shreg_q[14:0], 1'b0};
      end
      done_d = (state_q == StHold) && hdone;
      ovr_d  = tick && (state_q != StIdle);
   end

   always_ff @(posedge c50M or negedge reset_n) begin
      if (!reset_n) begin
         tmr_q   <= '0;
         hcnt_q  <= '0;
         phase_q <= 1'b0;
         bit_q   <= 4'd0;
         shreg_q <= 16'h0000;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         tmr_q   <= tmr_d;
         hcnt_q  <= hcnt_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
      end
   end

endmodule

// File: tb/tb_dac_spi_streamer.sv
// tb_dac_spi_streamer
// Scoreboard bench: a timer/occupancy model predicts each accepted tick and
// pushes the expected frame word and cs_n fall cycle; an SPI receiver pops and
// compares them. A second instance with SAMPLE_DIV=100 exercises overrun.
// Cycle convention: cyc counts falling edges; the first negedge after reset
// release (or enable rise) sees timer count 0, so cs_n is seen low SAMPLE_DIV
// negedges later.
module tb_dac_spi_streamer;

   localparam int SD = 6250;
   localparam int SK = 5;
   localparam int FL = 34 * SK;
   localparam int FSD = 100;

   logic       c50M = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] sample_in = 8'hA5;
   logic       enable = 1'b0;
   logic       mute = 1'b0;
   logic       dac_sclk, dac_mosi, dac_cs_n, busy, frame_done, overrun;

   logic       f_en = 1'b0;
   logic       f_sclk, f_mosi, f_cs_n, f_busy, f_done, f_ovr;

   always #10 c50M = ~c50M;

   dac_spi_streamer #(.SAMPLE_DIV(SD), .SCLK_DIV(SK), .CTRL_BITS(4'b0011)) u_dut (
      .c50M       (c50M),
      .reset_n    (reset_n),
      .sample_in  (sample_in),
      .enable     (enable),
`ifdef DAC_MUTE_EN
      .mute       (mute),
`endif
      .dac_sclk   (dac_sclk),
      .dac_mosi   (dac_mosi),
      .dac_cs_n   (dac_cs_n),
      .busy       (busy),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   dac_spi_streamer #(.SAMPLE_DIV(FSD), .SCLK_DIV(SK), .CTRL_BITS(4'b0011)) u_dut_fast (
      .c50M       (c50M),
      .reset_n    (reset_n),
      .sample_in  (8'h5A),
      .enable     (f_en),
`ifdef DAC_MUTE_EN
      .mute       (1'b0),
`endif
      .dac_sclk   (f_sclk),
      .dac_mosi   (f_mosi),
      .dac_cs_n   (f_cs_n),
      .busy       (f_busy),
      .frame_done (f_done),
      .overrun    (f_ovr)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Main model + receiver state
   int          cyc = 0;
   int          mcnt = 0, mrem = 0, n_ticks = 0;
   bit          m_tick;
   logic [15:0] q_word[$];
   int          q_fall[$];
   int          exp_ovr = 0, obs_ovr = 0;
   bit          p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0, p_rst = 1'b0, p_en = 1'b0;
   bit          in_frame = 1'b0, have_gap = 1'b0, want_rst = 1'b0, want_en = 1'b0;
   int          fall_cyc = 0, rise_cyc = 0, last_rise = 0, rel_cyc = 0, en_cyc = 0;
   int          rx_bits = 0, n_falls = 0, n_frames = 0;
   logic [15:0] rx_word = 16'h0;
   logic [7:0]  exp_sample;

   always @(negedge c50M) begin
      cyc++;
      if (!reset_n) begin
         mcnt = 0; mrem = 0; m_tick = 1'b0;
         q_word.delete(); q_fall.delete();
         in_frame = 1'b0; have_gap = 1'b0; rx_bits = 0;
         p_cs = 1'b1; p_sclk = 1'b0; p_mosi = 1'b0; p_rst = 1'b0;
      end else begin
         if (!p_rst) begin rel_cyc = cyc; want_rst = 1'b1; end
         p_rst = 1'b1;
         if (enable && !p_en) begin en_cyc = cyc; want_en = 1'b1; end
         p_en = enable;
         // sample timer and frame occupancy model
         m_tick = enable && (mcnt == SD - 1);
         if (m_tick) n_ticks++;
`ifdef DAC_MUTE_EN
         exp_sample = mute ? 8'h80 : sample_in;
`else
         exp_sample = sample_in;
`endif
         if (m_tick && mrem == 0) begin
            q_word.push_back({4'b0011, exp_sample, 4'b0000});
            q_fall.push_back(cyc + 1);
            mrem = FL;
         end else begin
            if (m_tick) exp_ovr++;
            if (mrem > 0) mrem--;
         end
         mcnt = enable ? (m_tick ? 0 : mcnt + 1) : 0;
         // receiver
         if (overrun) obs_ovr++;
         if (p_cs && !dac_cs_n) begin
            if (q_fall.size() == 0) check_eq("cs_fall_expected", 0, 1);
            else check_eq("cs_fall_time", cyc, q_fall.pop_front());
            if (have_gap) check_eq("cs_gap_ge_sclkdiv", int'((cyc - rise_cyc) >= SK), 1);
            if (want_rst) check_eq("fall_after_reset", cyc - rel_cyc, SD);
            if (want_en) check_eq("fall_after_enable", cyc - en_cyc, SD);
            want_rst = 1'b0; want_en = 1'b0;
            fall_cyc = cyc; in_frame = 1'b1; rx_bits = 0; n_falls++;
         end
         if (!dac_cs_n && !p_sclk && dac_sclk) begin
            rx_word = {rx_word[14:0], dac_mosi};
            check_eq("mosi_stable_at_rise", dac_mosi, p_mosi);
            if (rx_bits > 0) check_eq("sclk_period", cyc - last_rise, 2 * SK);
            last_rise = cyc; rx_bits++;
         end
         if (!p_cs && dac_cs_n) begin
            check_eq("bit_count", rx_bits, 16);
            check_eq("sclk_idle_at_cs_rise", dac_sclk, 0);
            check_eq("cs_low_len", cyc - fall_cyc, 33 * SK);
            if (q_word.size() == 0) check_eq("frame_expected", 0, 1);
            else check_eq("frame_data", rx_word, q_word.pop_front());
            rise_cyc = cyc; have_gap = 1'b1; in_frame = 1'b0; n_frames++;
         end
         if (frame_done) check_eq("done_time", cyc - fall_cyc, FL);
         p_cs = dac_cs_n; p_sclk = dac_sclk; p_mosi = dac_mosi;
      end
   end

   // Fast-instance model + receiver
   int          fcnt = 0, frem = 0, f_exp_ovr = 0, f_obs_ovr = 0;
   int          f_exp_frames = 0, f_obs_frames = 0, f_obs_done = 0, f_bits = 0;
   bit          f_tick, fp_cs = 1'b1, fp_sclk = 1'b0;
   logic [15:0] f_word = 16'h0;

   always @(negedge c50M) begin
      if (!reset_n) begin
         fcnt = 0; frem = 0; fp_cs = 1'b1; fp_sclk = 1'b0; f_bits = 0;
      end else begin
         f_tick = f_en && (fcnt == FSD - 1);
         if (f_tick && frem == 0) begin
            frem = FL; f_exp_frames++;
         end else begin
            if (f_tick) f_exp_ovr++;
            if (frem > 0) frem--;
         end
         fcnt = f_en ? (f_tick ? 0 : fcnt + 1) : 0;
         if (f_ovr) f_obs_ovr++;
         if (f_done) f_obs_done++;
         if (fp_cs && !f_cs_n) f_bits = 0;
         if (!f_cs_n && !fp_sclk && f_sclk) begin
            f_word = {f_word[14:0], f_mosi};
            f_bits++;
         end
         if (!fp_cs && f_cs_n) begin
            check_eq("fast_bits", f_bits, 16);
            check_eq("fast_frame", f_word, 16'h35A0);
            f_obs_frames++;
         end
         fp_cs = f_cs_n; fp_sclk = f_sclk;
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge c50M);
      #1;
   endtask

   task automatic wait_frames(input int n, input int budget);
      int target = n_frames + n;
      int t = 0;
      while (n_frames < target && t < budget) begin
         wait_cycles(1);
         t++;
      end
      check_eq("frame_wait_timeout", int'(n_frames >= target), 1);
   endtask

   task automatic wait_tick(input int budget);
      int target = n_ticks + 1;
      int t = 0;
      while (n_ticks < target && t < budget) begin
         wait_cycles(1);
         t++;
      end
      check_eq("tick_wait_timeout", int'(n_ticks >= target), 1);
   endtask

   task automatic wait_bits(input int nb, input int budget);
      int t = 0;
      while (!(in_frame && rx_bits == nb) && t < budget) begin
         wait_cycles(1);
         t++;
      end
      check_eq("bit_wait_timeout", int'(in_frame && rx_bits == nb), 1);
   endtask

   int f0;

   initial begin
      wait_cycles(5);
      check_eq("reset_cs_n", dac_cs_n, 1);
      check_eq("reset_sclk", dac_sclk, 0);
      check_eq("reset_mosi", dac_mosi, 0);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_done", frame_done, 0);
      check_eq("reset_overrun", overrun, 0);
      reset_n = 1'b1; enable = 1'b1; f_en = 1'b1;

      // Fast instance runs ~10 ticks alongside the first main frame
      wait_cycles(1000);
      f_en = 1'b0;
      wait_frames(1, SD + 400);

      // Sample changes the cycle after the tick: 00 transmitted, FF next
      sample_in = 8'h00;
      wait_tick(SD + 10);
      sample_in = 8'hFF;
      wait_frames(2, 2 * SD + 400);

      // Drop enable mid-frame
      wait_bits(3, SD + 400);
      enable = 1'b0;
      wait_frames(1, 400);
      f0 = n_falls;
      wait_cycles(20000);
      check_eq("no_cs_while_disabled", n_falls, f0);
      enable = 1'b1;
      wait_frames(1, SD + 400);

      // Reset during the 8th bit (low half)
      wait_bits(7, SD + 400);
      wait_cycles(SK + 2);
      #2 reset_n = 1'b0;
      #1;
      check_eq("midreset_cs_n", dac_cs_n, 1);
      check_eq("midreset_sclk", dac_sclk, 0);
      check_eq("midreset_mosi", dac_mosi, 0);
      check_eq("midreset_busy", busy, 0);
      wait_cycles(3);
      reset_n = 1'b1;
      wait_frames(1, SD + 400);

`ifdef DAC_MUTE_EN
      mute = 1'b1; sample_in = 8'h3C;
      wait_frames(1, SD + 400);
      mute = 1'b0;
`endif

      wait_cycles(10);
      check_eq("main_overrun", obs_ovr, exp_ovr);
      check_eq("pending_frames", q_word.size(), 0);
      check_eq("fast_overrun_seen", int'(f_obs_ovr > 0), 1);
      check_eq("fast_overrun_count", f_obs_ovr, f_exp_ovr);
      check_eq("fast_frame_count", f_obs_frames, f_exp_frames);
      check_eq("fast_done_count", f_obs_done, f_exp_frames);
      check_eq("fast_idle", f_busy, 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
